// File: rtl/regfile_pkg.sv
// Shared widths, types and the address decoder for the register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  function automatic logic [(1 << RF_ADDR_W)-1:0] onehot_dec(input rf_addr_t addr);
    logic [(1 << RF_ADDR_W)-1:0] dec;
    dec       = '0;
    dec[addr] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with alloc/retire/flush priority and a running pending count
// that always equals the popcount of the bit vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_ret_en,
  input  logic [ADDR_W-1:0]        i_ret_addr,
  input  logic                     i_flush,
  output logic [(1 << ADDR_W)-1:0] o_pend,
  output logic [ADDR_W:0]          o_pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [ADDR_W:0]  r_pend_cnt;
  logic [DEPTH-1:0] w_alloc_dec;
  logic [DEPTH-1:0] w_ret_dec;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [ADDR_W:0]  w_cnt_nxt;
  logic             w_alloc;
  logic             w_ret;
  logic             w_inc;
  logic             w_dec;

  if (ADDR_W == RF_ADDR_W) begin : g_pkg_dec
    assign w_alloc_dec = onehot_dec(i_alloc_addr);
    assign w_ret_dec   = onehot_dec(i_ret_addr);
  end else begin : g_gen_dec
    always_comb begin
      w_alloc_dec = '0;
      w_ret_dec   = '0;
      w_alloc_dec[i_alloc_addr] = 1'b1;
      w_ret_dec[i_ret_addr]     = 1'b1;
    end
  end

  assign w_alloc = i_alloc_en && (i_alloc_addr != '0);
  assign w_ret   = i_ret_en && (i_ret_addr != '0);

  // A same-address alloc keeps the bit set, so the retire must not decrement.
  assign w_inc = w_alloc && !r_pend[i_alloc_addr];
  assign w_dec = w_ret && r_pend[i_ret_addr] && !(w_alloc && (i_alloc_addr == i_ret_addr));

  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = r_pend_cnt;
    if (i_flush) begin
      w_pend_nxt = '0;
      w_cnt_nxt  = '0;
    end else begin
      if (w_ret) w_pend_nxt = w_pend_nxt & ~w_ret_dec;
      if (w_alloc) w_pend_nxt = w_pend_nxt | w_alloc_dec;
      w_cnt_nxt = r_pend_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign o_pend     = r_pend;
  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: rtl/regfile_sb.sv
// RV32 register file with NUM_RD combinational read ports and a pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_pending,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [DATA_W-1:0]        i_rd_data,
  input  logic                     i_rd_wren,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_flush,
  output logic [ADDR_W:0]          o_pend_cnt,
  output logic                     o_sb_full
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_pend;
  logic              w_wr;

  assign w_wr = i_rd_wren && (i_rd_addr != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_ret_en     (i_rd_wren),
    .i_ret_addr   (i_rd_addr),
    .i_flush      (i_flush),
    .o_pend       (w_pend),
    .o_pend_cnt   (o_pend_cnt)
  );

  assign o_sb_full = (o_pend_cnt == (ADDR_W + 1)'(DEPTH - 1));

`ifdef REGFILE_BYPASS_EN
  // Reset must win over forwarding so reads stay zero while i_reset is high.
  logic w_byp_wr;
  assign w_byp_wr = w_wr && !i_reset;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_byp;

    assign w_addr = i_rs_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign w_byp = w_byp_wr && (w_addr == i_rd_addr);
`else
    assign w_byp = 1'b0;
`endif
    assign o_rs_data[k*DATA_W +: DATA_W] = w_byp            ? i_rd_data :
                                           (w_addr == '0)   ? '0        : r_regs[w_addr];
    assign o_rs_pending[k] = !w_byp && (w_addr != '0) && w_pend[w_addr];
  end

endmodule
